inst_fetch_unit: RTL

- Parametrised instruction-fetch front end: PC register, incrementer and a synchronous-read instruction ROM (1-cycle BRAM latency) behind a valid/stall interface.
- Supports redirect (branch/jump) with flush, stall with a skid/hold register so no instruction is lost or duplicated, and configurable PC/address widths and step.
- Sits between the instruction BRAM and the decode stage of the miniRISC core.

---
 rtl/inst_fetch_unit.sv | 85 ++++++++
 1 files changed

// File: rtl/inst_fetch_unit.sv
// Instruction-fetch front end: PC register, incrementer and a skid/hold register in front of a 1-cycle synchronous ROM.
// Optional perf counters (fetch_cnt, redirect_cnt) are enabled by defining IFU_PERF_CNT_EN.
module inst_fetch_unit #(
  parameter int              PC_W     = 32,
  parameter int              DATA_W   = 32,
  parameter int              ADDR_W   = 12,
  parameter int              ADDR_LSB = 0,
  parameter int              STEP     = 1,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] inst,
  output logic [PC_W-1:0]   inst_pc,
  output logic              inst_valid
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_cnt,
  output logic [31:0]       redirect_cnt
`endif
);

  logic [PC_W-1:0]   r_pc;
  logic [PC_W-1:0]   r_pc_q;
  logic              r_valid_q;
  logic [DATA_W-1:0] r_hold;
  logic              r_hold_active;
  logic [PC_W-1:0]   w_pc_next;

  assign w_pc_next  = r_pc + PC_W'(STEP);
  assign mem_addr   = r_pc[ADDR_LSB+ADDR_W-1:ADDR_LSB];
  assign inst_valid = r_valid_q;
  assign inst_pc    = r_pc_q;
  assign inst       = !r_valid_q ? '0 : (r_hold_active ? r_hold : mem_rdata);

  // The ROM keeps reading r_pc during a stall, so the hold register only has to
  // capture the word on screen once; on release mem_rdata is already ROM[r_pc].
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc          <= RESET_PC;
      r_pc_q        <= '0;
      r_valid_q     <= 1'b0;
      r_hold        <= '0;
      r_hold_active <= 1'b0;
    end else if (redirect_valid) begin
      r_pc          <= redirect_pc;
      r_valid_q     <= 1'b0;
      r_hold_active <= 1'b0;
    end else if (stall) begin
      if (!r_hold_active) begin
        r_hold        <= mem_rdata;
        r_hold_active <= 1'b1;
      end
    end else begin
      r_pc          <= w_pc_next;
      r_pc_q        <= r_pc;
      r_valid_q     <= 1'b1;
      r_hold_active <= 1'b0;
    end
  end

`ifdef IFU_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_redirect_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_cnt    <= '0;
      r_redirect_cnt <= '0;
    end else begin
      if (r_valid_q && !stall) r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (redirect_valid)      r_redirect_cnt <= r_redirect_cnt + 32'd1;
    end
  end

  assign fetch_cnt    = r_fetch_cnt;
  assign redirect_cnt = r_redirect_cnt;
`endif

endmodule
